// File: rtl/fc_layer_seq_pkg.sv
// Shared definitions for the fully-connected layer sequencer: state encoding,
// default widths and the MNIST layer shape.
package fc_layer_seq_pkg;

   localparam int DEF_MAC_LAT = 2;
   localparam int DEF_LEN_W   = 10;
   localparam int DEF_GRP_W   = 6;
   localparam int DEF_WADDR_W = 16;

   localparam int MNIST_IN  = 784;
   localparam int MNIST_OUT = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_MAC,
      S_DRAIN,
      S_BIAS,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_e;

   // Number of 4-lane groups needed to cover a given neuron count.
   function automatic int grp_count(input int neurons);
      return (neurons + 3) / 4;
   endfunction

endpackage

// File: rtl/fc_layer_seq.sv
// Sequences one fully-connected layer, four neurons at a time, over the shared
// MAC array and the bias/ReLU stage.
//
// state | meaning
// IDLE  | waiting for start, bias stage held cleared
// CLEAR | zero accumulators, fetch bias word for group g
// MAC   | stream in_len input/weight pairs
// DRAIN | let the MAC pipeline settle (MAC_LAT+1 cycles)
// BIAS  | load result plus bias into the bias stage
// WRITE | store packed result word for group g
// DONE  | one-cycle completion pulse
// ERR   | illegal configuration, completion pulse with err
module fc_layer_seq
   import fc_layer_seq_pkg::*;
#(
   parameter int MAC_LAT = DEF_MAC_LAT,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int GRP_W   = DEF_GRP_W,
   parameter int WADDR_W = DEF_WADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LEN_W-1:0]   in_len,
   input  logic [GRP_W:0]     n_grp,
   input  logic               relu_cfg,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               in_rd_en,
   output logic [LEN_W-1:0]   in_addr,
   output logic               w_rd_en,
   output logic [WADDR_W-1:0] w_addr,
   output logic               bias_rd_en,
   output logic [GRP_W-1:0]   bias_addr,
   output logic               mac_clr,
   output logic               mac_en,
   output logic               ba_en,
   output logic               ba_add,
   output logic               ba_relu,
   output logic               out_wr_en,
   output logic [GRP_W-1:0]   out_addr
);

   localparam int TMR_W = $clog2(MAC_LAT + 1) + 1;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   k_q, k_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [GRP_W-1:0]   g_q, g_d;
   logic [GRP_W:0]     ngrp_q, ngrp_d;
   logic               relu_q, relu_d;
   logic [WADDR_W-1:0] w_addr_q, w_addr_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               mac_en_q;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      len_d      = len_q;
      g_d        = g_q;
      ngrp_d     = ngrp_q;
      relu_d     = relu_q;
      w_addr_d   = w_addr_q;
      tmr_d      = tmr_q;
      done       = 1'b0;
      err        = 1'b0;
      in_rd_en   = 1'b0;
      in_addr    = '0;
      w_rd_en    = 1'b0;
      w_addr     = '0;
      bias_rd_en = 1'b0;
      bias_addr  = '0;
      mac_clr    = 1'b0;
      ba_en      = 1'b0;
      ba_add     = 1'b0;
      ba_relu    = 1'b0;
      out_wr_en  = 1'b0;
      out_addr   = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (in_len == '0 || n_grp == '0) begin
                  state_d = S_ERR;
               end else begin
                  len_d    = in_len;
                  ngrp_d   = n_grp;
                  relu_d   = relu_cfg;
                  g_d      = '0;
                  k_d      = '0;
                  w_addr_d = '0;
                  state_d  = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            mac_clr    = 1'b1;
            bias_rd_en = 1'b1;
            bias_addr  = g_q;
            ba_relu    = relu_q;
            k_d        = '0;
            state_d    = S_MAC;
         end
         S_MAC: begin
            in_rd_en = 1'b1;
            w_rd_en  = 1'b1;
            in_addr  = k_q;
            w_addr   = w_addr_q;
            ba_relu  = relu_q;
            // weight address runs on across groups: rows are stored back to back
            w_addr_d = w_addr_q + WADDR_W'(1);
            k_d      = k_q + LEN_W'(1);
            if (k_q == len_q - LEN_W'(1)) begin
               tmr_d   = TMR_W'(MAC_LAT);
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            ba_relu = relu_q;
            if (tmr_q == '0) begin
               state_d = S_BIAS;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_BIAS: begin
            ba_en   = 1'b1;
            ba_add  = 1'b1;
            ba_relu = relu_q;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            ba_en     = 1'b1;
            ba_relu   = relu_q;
            out_wr_en = 1'b1;
            out_addr  = g_q;
            if ({1'b0, g_q} == ngrp_q - (GRP_W + 1)'(1)) begin
               state_d = S_DONE;
            end else begin
               g_d     = g_q + GRP_W'(1);
               state_d = S_CLEAR;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            done    = 1'b1;
            err     = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy   = (state_q != S_IDLE);
   assign mac_en = mac_en_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         len_q    <= '0;
         g_q      <= '0;
         ngrp_q   <= '0;
         relu_q   <= 1'b0;
         w_addr_q <= '0;
         tmr_q    <= '0;
         mac_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         len_q    <= len_d;
         g_q      <= g_d;
         ngrp_q   <= ngrp_d;
         relu_q   <= relu_d;
         w_addr_q <= w_addr_d;
         tmr_q    <= tmr_d;
         // operands arrive one cycle after the buffer read strobe
         mac_en_q <= in_rd_en;
      end
   end

endmodule
